// File: rtl/flash_ctrl.sv
// NOR flash controller: read, program and (with FLASH_CTRL_ERASE_EN) block erase with status polling.
// A request is accepted only when req_ready is high; completion is a single rsp_valid pulse.
module flash_ctrl #(
   parameter int ADDR_W = 24,
   parameter int DATA_W = 16,
   parameter int T_ACC  = 6,
   parameter int T_WP   = 4,
   parameter int T_TMO  = 65535
) (
   input  logic              CLK,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_error,
   output logic              NF_CE,
   output logic              NF_OE,
   output logic              NF_WE,
   output logic              NF_RP,
   output logic              NF_WP,
   output logic              NF_BYTE,
   input  logic              NF_STS,
   output logic [ADDR_W-1:0] NF_A,
   output logic [DATA_W-1:0] NF_D_o,
   input  logic [DATA_W-1:0] NF_D_i,
   output logic              NF_D_oe
);
   localparam int TW = (T_TMO < 2) ? 1 : $clog2(T_TMO);
   localparam logic [8:0]        WR_END    = 9'(T_WP + 2);
   localparam logic [8:0]        RD_SMP    = 9'(T_ACC - 1);
   localparam logic [8:0]        RD_END    = 9'(T_ACC);
   localparam logic [TW-1:0]     POLL_LAST = TW'(T_TMO - 1);
   localparam logic [DATA_W-1:0] CMD_PROG  = DATA_W'(8'h40);
   localparam logic [DATA_W-1:0] CMD_CLRSR = DATA_W'(8'h50);
   localparam logic [DATA_W-1:0] CMD_RDARR = DATA_W'(8'hFF);
`ifdef FLASH_CTRL_ERASE_EN
   localparam logic [DATA_W-1:0] CMD_ERASE = DATA_W'(8'h20);
   localparam logic [DATA_W-1:0] CMD_CONF  = DATA_W'(8'hD0);
`endif

   typedef enum logic [2:0] {IDLE, BUS_WR, BUS_RD, POLL, CLRSR, RDARR, DONE} state_t;

   state_t            state, state_nx;
   logic [8:0]        cnt;
   logic              step, err, sts;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata, rdata, wr_val;
   logic [TW-1:0]     polls;
   logic [1:0]        boot;
   logic              accept, bad_op, is_wr, wr_end, rd_smp, poll_end, poll_ok, sr_fail, timeout;
`ifdef FLASH_CTRL_ERASE_EN
   logic              erase;
   assign bad_op = (req_op == 2'b11);
`else
   assign bad_op = req_op[1];
`endif

   assign accept   = req_valid && req_ready;
   assign is_wr    = state inside {BUS_WR, CLRSR, RDARR};
   assign wr_end   = is_wr && (cnt == WR_END);
   assign rd_smp   = (state == BUS_RD || state == POLL) && (cnt == RD_SMP);
   assign poll_end = (state == POLL) && (cnt == RD_END);
   assign poll_ok  = rdata[7] && sts;
   assign sr_fail  = rdata[5] | rdata[4] | rdata[3] | rdata[1];
   assign timeout  = (polls == POLL_LAST);

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // A plain read ends on its sample cycle: the DONE cycle doubles as the strobes-high recovery.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = bad_op ? DONE : ((req_op == 2'b00) ? BUS_RD : BUS_WR);
         BUS_RD:  if (rd_smp) state_nx = DONE;
         BUS_WR:  if (wr_end && step) state_nx = POLL;
         POLL:    if (poll_end) begin
                     if (poll_ok)      state_nx = sr_fail ? CLRSR : RDARR;
                     else if (timeout) state_nx = RDARR;
                  end
         CLRSR:   if (wr_end) state_nx = RDARR;
         RDARR:   if (wr_end) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         boot  <= '0;
         cnt   <= '0;
         step  <= 1'b0;
         err   <= 1'b0;
         sts   <= 1'b0;
         addr  <= '0;
         wdata <= '0;
         rdata <= '0;
         polls <= '0;
`ifdef FLASH_CTRL_ERASE_EN
         erase <= 1'b0;
`endif
      end else begin
         if (boot != 2'd3) boot <= boot + 2'd1;
         if (state_nx != state || wr_end || poll_end || state == IDLE) cnt <= '0;
         else                                                          cnt <= cnt + 9'd1;
         if (accept) begin
            addr  <= req_addr;
            wdata <= req_wdata;
            err   <= bad_op;
            step  <= 1'b0;
            polls <= '0;
`ifdef FLASH_CTRL_ERASE_EN
            erase <= (req_op == 2'b10);
`endif
         end
         if (state == BUS_WR && wr_end) step <= 1'b1;
         if (rd_smp) begin
            rdata <= NF_D_i;
            sts   <= NF_STS;
         end
         if (poll_end) begin
            if (poll_ok) begin
               if (sr_fail) err <= 1'b1;
            end else begin
               polls <= polls + TW'(1);
               if (timeout) err <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      wr_val = CMD_RDARR;
      case (state)
         CLRSR:  wr_val = CMD_CLRSR;
         BUS_WR: begin
            wr_val = step ? wdata : CMD_PROG;
`ifdef FLASH_CTRL_ERASE_EN
            if (erase) wr_val = step ? CMD_CONF : CMD_ERASE;
`endif
         end
         default: wr_val = CMD_RDARR;
      endcase
   end

   // Write cycle: setup, T_WP cycles WE low, WE-high hold, CE-high recovery.
   always_comb begin
      NF_CE   = 1'b1;
      NF_OE   = 1'b1;
      NF_WE   = 1'b1;
      NF_D_oe = 1'b0;
      NF_D_o  = '0;
      if (is_wr) begin
         NF_CE   = (cnt == WR_END);
         NF_WE   = !(cnt != 9'd0 && cnt <= 9'(T_WP));
         NF_D_oe = (cnt != WR_END);
         NF_D_o  = wr_val;
      end else if ((state == BUS_RD || state == POLL) && cnt < RD_END) begin
         NF_CE = 1'b0;
         NF_OE = 1'b0;
      end
      req_ready = (state == IDLE) && (boot == 2'd3);
      rsp_valid = (state == DONE);
      rsp_error = (state == DONE) && err;
   end

   assign rsp_rdata = rdata;
   assign NF_A      = addr;
   assign NF_RP     = (boot != 2'd0);
   assign NF_WP     = !rst;
   assign NF_BYTE   = (DATA_W == 16) ? 1'b1 : 1'b0;
endmodule
